router_in_buf: RTL and testbench

ROUTER_IN_BUF -- requirements
Module: router_in_buf

---
 rtl/router_in_buf.sv | 150 +++++++++++++++
 tb/tb_router_in_buf.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_in_buf.sv
// Router input buffer: flit FIFO plus a head-flit routing FSM (IDLE/ROUTE/LATCH/ACTIVE).
// Optional sticky drop flag "err" is enabled by defining ROUTER_IN_BUF_ERR_EN.
module router_in_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_flit,
    output logic             in_ready,
    output logic             rc_en,
    output logic [2:0]       rc_dst,
    input  logic [2:0]       rc_port,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_flit,
    output logic [2:0]       out_port,
    input  logic             out_ready
`ifdef ROUTER_IN_BUF_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        LATCH,
        ACTIVE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] front;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic             xfer;
    logic             front_head;
    logic             front_tail;

    // Type bit 14 marks a head (01/11), bit 15 marks a tail (10/11).
    assign front      = mem[rd_ptr];
    assign front_head = front[14];
    assign front_tail = front[15];
    assign empty      = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign pop        = xfer || drop;
    assign rc_dst     = front[13:11];
    assign out_flit   = front;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The head stays at the FIFO front through ROUTE and LATCH, so it leaves first.
    always_comb begin
        next_state = state;
        rc_en      = 1'b0;
        out_valid  = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (front_head) begin
                        next_state = ROUTE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ROUTE: begin
                rc_en      = 1'b1;
                next_state = LATCH;
            end
            LATCH: begin
                next_state = ACTIVE;
            end
            ACTIVE: begin
                out_valid = !empty;
                if (out_valid && out_ready && front_tail) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port <= 3'b000;
        end else if (state == LATCH) begin
            out_port <= rc_port;
        end
    end

`ifdef ROUTER_IN_BUF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_router_in_buf.sv
// Directed self-checking bench for router_in_buf: routing latency, backpressure,
// head+tail packets, stray-flit drop, mid-packet reset and full-FIFO streaming.
module tb_router_in_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_flit;
    logic        in_ready;
    logic        rc_en;
    logic [2:0]  rc_dst;
    logic [2:0]  rc_port;
    logic        out_valid;
    logic [15:0] out_flit;
    logic [2:0]  out_port;
    logic        out_ready;
`ifdef ROUTER_IN_BUF_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    router_in_buf #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .rc_en     (rc_en),
        .rc_dst    (rc_dst),
        .rc_port   (rc_port),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_port  (out_port),
        .out_ready (out_ready)
`ifdef ROUTER_IN_BUF_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] f);
        in_valid = v;
        in_flit  = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rc_port   = 3'b000;
        out_ready = 1'b0;
        applyStimulus(1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_rc_en", 32'(rc_en), 32'd0);
        checkOutput("rst_out_port", 32'(out_port), 32'd0);
`ifdef ROUTER_IN_BUF_ERR_EN
        checkOutput("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;

        // Single head 0x5A01 (dst 011), route answer 010.
        rc_port   = 3'b010;
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h5A01);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t1_idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_rc_dst", 32'(rc_dst), 32'd3);
        checkOutput("t1_idle_rc_en", 32'(rc_en), 32'd0);
        tick();
        checkOutput("t1_route_rc_en", 32'(rc_en), 32'd1);
        checkOutput("t1_route_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1_latch_rc_en", 32'(rc_en), 32'd0);
        checkOutput("t1_latch_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1_active_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_out_port", 32'(out_port), 32'd2);
        checkOutput("t1_out_flit", 32'(out_flit), 32'h5A01);
        tick();
        checkOutput("t1_empty_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_hold_out_port", 32'(out_port), 32'd2);
        applyStimulus(1'b1, 16'h8077);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t1_tail_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_tail_out_flit", 32'(out_flit), 32'h8077);
        tick();
        checkOutput("t1_idle_again", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1_no_reroute", 32'(rc_en), 32'd0);

        // Four-flit packet under backpressure.
        rc_port   = 3'b101;
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h6C10);
        tick();
        applyStimulus(1'b1, 16'h0011);
        tick();
        applyStimulus(1'b1, 16'h0022);
        tick();
        applyStimulus(1'b1, 16'h8033);
        tick();
        checkOutput("t2_full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_head", 32'(out_flit), 32'h6C10);
        checkOutput("t2_out_port", 32'(out_port), 32'd5);
        applyStimulus(1'b1, 16'h4844);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t2_fifth_rejected", 32'(in_ready), 32'd0);
        checkOutput("t2_head_held", 32'(out_flit), 32'h6C10);
        out_ready = 1'b1;
        tick();
        checkOutput("t2_flit1", 32'(out_flit), 32'h0011);
        tick();
        checkOutput("t2_flit2", 32'(out_flit), 32'h0022);
        tick();
        checkOutput("t2_flit3", 32'(out_flit), 32'h8033);
        checkOutput("t2_flit3_valid", 32'(out_valid), 32'd1);
        tick();
        checkOutput("t2_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t2_no_extra_rc_a", 32'(rc_en), 32'd0);
        tick();
        checkOutput("t2_no_extra_rc_b", 32'(rc_en), 32'd0);

        // Head+tail flit 0xC8FF (dst 001), then a fresh head 0x5001 (dst 010).
        rc_port = 3'b111;
        applyStimulus(1'b1, 16'hC8FF);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t3_rc_dst", 32'(rc_dst), 32'd1);
        tick();
        checkOutput("t3_rc_en", 32'(rc_en), 32'd1);
        tick();
        tick();
        checkOutput("t3_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_out_flit", 32'(out_flit), 32'hC8FF);
        checkOutput("t3_out_port", 32'(out_port), 32'd7);
        tick();
        checkOutput("t3_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t3_no_rc", 32'(rc_en), 32'd0);
        rc_port = 3'b011;
        applyStimulus(1'b1, 16'h5001);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t3b_rc_dst", 32'(rc_dst), 32'd2);
        tick();
        checkOutput("t3b_rc_en", 32'(rc_en), 32'd1);
        tick();
        tick();
        checkOutput("t3b_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t3b_out_port", 32'(out_port), 32'd3);
        checkOutput("t3b_out_flit", 32'(out_flit), 32'h5001);
        applyStimulus(1'b1, 16'h8000);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t3b_tail", 32'(out_flit), 32'h8000);
        tick();
        checkOutput("t3b_idle", 32'(out_valid), 32'd0);

        // Stray body flit in IDLE is dropped.
`ifdef ROUTER_IN_BUF_ERR_EN
        checkOutput("t4_err_before", 32'(err), 32'd0);
`endif
        applyStimulus(1'b1, 16'h0012);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t4_out_valid_a", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t4_out_valid_b", 32'(out_valid), 32'd0);
        checkOutput("t4_rc_en", 32'(rc_en), 32'd0);
`ifdef ROUTER_IN_BUF_ERR_EN
        checkOutput("t4_err_set", 32'(err), 32'd1);
`endif
        tick();
        checkOutput("t4_rc_en_later", 32'(rc_en), 32'd0);

        // Reset mid-packet after two flits have left.
        rc_port = 3'b100;
        applyStimulus(1'b1, 16'h7001);
        tick();
        applyStimulus(1'b1, 16'h0101);
        tick();
        applyStimulus(1'b1, 16'h0202);
        tick();
        applyStimulus(1'b1, 16'h8303);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t5_head", 32'(out_flit), 32'h7001);
        tick();
        checkOutput("t5_body1", 32'(out_flit), 32'h0101);
        tick();
        checkOutput("t5_body2_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_rc_en", 32'(rc_en), 32'd0);
        checkOutput("t5_rst_out_port", 32'(out_port), 32'd0);
        checkOutput("t5_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ROUTER_IN_BUF_ERR_EN
        checkOutput("t5_rst_err", 32'(err), 32'd0);
`endif
        tick();
        rst     = 1'b0;
        rc_port = 3'b010;
        applyStimulus(1'b1, 16'h5A01);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t5_new_rc_dst", 32'(rc_dst), 32'd3);
        tick();
        checkOutput("t5_new_rc_en", 32'(rc_en), 32'd1);
        tick();
        tick();
        checkOutput("t5_new_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_new_out_flit", 32'(out_flit), 32'h5A01);
        checkOutput("t5_new_out_port", 32'(out_port), 32'd2);
        applyStimulus(1'b1, 16'h8001);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t5_new_tail", 32'(out_flit), 32'h8001);
        tick();
        checkOutput("t5_idle", 32'(out_valid), 32'd0);

        // Full FIFO streaming: push and pop together for 8 cycles.
        rc_port   = 3'b001;
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h4000);
        tick();
        applyStimulus(1'b1, 16'h0001);
        tick();
        applyStimulus(1'b1, 16'h0002);
        tick();
        applyStimulus(1'b1, 16'h0003);
        tick();
        checkOutput("t6_full", 32'(in_ready), 32'd0);
        checkOutput("t6_head", 32'(out_flit), 32'h4000);
        checkOutput("t6_out_port", 32'(out_port), 32'd1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0004);
        tick();
        checkOutput("t6_first_pop", 32'(out_flit), 32'h0001);
        checkOutput("t6_first_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i <= 9; i++) begin
            applyStimulus(1'b1, 16'(i + 2));
            tick();
            checkOutput($sformatf("t6_stream_flit_%0d", i), 32'(out_flit), 32'(i));
            checkOutput($sformatf("t6_stream_ready_%0d", i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("t6_stream_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        applyStimulus(1'b0, 16'h0000);
        tick();
        checkOutput("t6_drain_a", 32'(out_flit), 32'h000A);
        tick();
        checkOutput("t6_drain_b", 32'(out_flit), 32'h000B);
        tick();
        checkOutput("t6_empty", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 16'h8005);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t6_tail", 32'(out_flit), 32'h8005);
        tick();
        checkOutput("t6_idle", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t6_no_rc", 32'(rc_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
